// File: rtl/servo_pwm_decoder.sv
// -----------------------------------------------------------------------------
// servo_pwm_decoder
//
// Measures the high time of an incoming 50 Hz servo PWM signal and converts it
// back to an angle code (0..MAX_ANGLE). It also reports short pulses, overlong
// pulses and loss of signal.
//
// Ports
//   clk          system clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   pwm_in       asynchronous PWM input from the pin
//   angle        last decoded angle, 0..MAX_ANGLE
//   angle_valid  one-cycle pulse when angle/pulse_width are updated
//   pulse_width  last legal measured high time in clk cycles
//   err_short    one-cycle pulse: completed pulse shorter than MIN_CYC
//   err_long     one-cycle pulse: high time exceeded MAX_CYC
//   signal_lost  level: no rising edge seen for TIMEOUT_CYC cycles
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | wait for the line to be low; a pulse in progress is ignored
// ARMED   | line low, wait for a rising edge
// MEASURE | line high, counting width, prescaler and degree accumulator
// -----------------------------------------------------------------------------
module servo_pwm_decoder #(
    parameter int MIN_CYC     = 25000,
    parameter int MAX_CYC     = 125000,
    parameter int CYC_PER_DEG = 555,
    parameter int MAX_ANGLE   = 180,
    parameter int TIMEOUT_CYC = 1250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [7:0]  angle,
    output logic        angle_valid,
    output logic [16:0] pulse_width,
    output logic        err_short,
    output logic        err_long,
    output logic        signal_lost
);

    localparam int PRESC_W = $clog2(CYC_PER_DEG + 1);

    localparam logic [16:0]        MIN_W      = 17'(MIN_CYC);
    localparam logic [16:0]        MAX_W      = 17'(MAX_CYC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYC_PER_DEG - 1);
    localparam logic [7:0]         ANGLE_SAT  = 8'(MAX_ANGLE);
    localparam logic [20:0]        TIMEOUT_W  = 21'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic                 s_meta, s_sync, s_dly;
    logic                 rise;
    logic [16:0]          width, width_nxt;
    logic [PRESC_W-1:0]   presc, presc_nxt;
    logic [7:0]           deg, deg_nxt;
    logic [20:0]          wd_cnt, wd_cnt_nxt;
    logic [7:0]           angle_nxt;
    logic [16:0]          pulse_width_nxt;
    logic                 valid_nxt, short_nxt, long_nxt, lost_nxt;

    // The synchronizer resets to "high" so that a line that is already high
    // at reset release is not mistaken for a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b1;
            s_sync <= 1'b1;
            s_dly  <= 1'b1;
        end else begin
            s_meta <= pwm_in;
            s_sync <= s_meta;
            s_dly  <= s_sync;
        end
    end

    assign rise = s_sync & ~s_dly;

    always_comb begin
        state_nxt       = state;
        width_nxt       = width;
        presc_nxt       = presc;
        deg_nxt         = deg;
        angle_nxt       = angle;
        pulse_width_nxt = pulse_width;
        valid_nxt       = 1'b0;
        short_nxt       = 1'b0;
        long_nxt        = 1'b0;

        case (state)
            IDLE: begin
                if (!s_sync) state_nxt = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    state_nxt = MEASURE;
                    width_nxt = 17'd1;
                    presc_nxt = '0;
                    deg_nxt   = '0;
                end
            end
            MEASURE: begin
                if (s_sync) begin
                    if (width == MAX_W) begin
                        // This high cycle would make the count MAX_CYC+1.
                        long_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        width_nxt = width + 17'd1;
                        // Each step past MIN_CYC advances the prescaler, so after
                        // the fall deg == floor((W-MIN_CYC)/CYC_PER_DEG), saturated.
                        if (width >= MIN_W) begin
                            if (presc == PRESC_LAST) begin
                                presc_nxt = '0;
                                if (deg != ANGLE_SAT) deg_nxt = deg + 8'd1;
                            end else begin
                                presc_nxt = presc + PRESC_W'(1);
                            end
                        end
                    end
                end else begin
                    state_nxt = ARMED;
                    if (width < MIN_W) begin
                        short_nxt = 1'b1;
                    end else begin
                        valid_nxt       = 1'b1;
                        angle_nxt       = deg;
                        pulse_width_nxt = width;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (rise)                    wd_cnt_nxt = '0;
        else if (wd_cnt != TIMEOUT_W) wd_cnt_nxt = wd_cnt + 21'd1;
        else                         wd_cnt_nxt = wd_cnt;

        if (valid_nxt)               lost_nxt = 1'b0;
        else if (wd_cnt == TIMEOUT_W) lost_nxt = 1'b1;
        else                         lost_nxt = signal_lost;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            width       <= '0;
            presc       <= '0;
            deg         <= '0;
            wd_cnt      <= '0;
            angle       <= '0;
            pulse_width <= '0;
            angle_valid <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            signal_lost <= 1'b0;
        end else begin
            state       <= state_nxt;
            width       <= width_nxt;
            presc       <= presc_nxt;
            deg         <= deg_nxt;
            wd_cnt      <= wd_cnt_nxt;
            angle       <= angle_nxt;
            pulse_width <= pulse_width_nxt;
            angle_valid <= valid_nxt;
            err_short   <= short_nxt;
            err_long    <= long_nxt;
            signal_lost <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for servo_pwm_decoder. Timing constants are scaled down so the
// whole run stays short; the decode rules are the same as at full scale.
// -----------------------------------------------------------------------------
module tb_servo_pwm_decoder;

    localparam int MIN_CYC     = 40;
    localparam int MAX_CYC     = 600;
    localparam int CYC_PER_DEG = 3;
    localparam int MAX_ANGLE   = 180;
    localparam int TIMEOUT_CYC = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwm_in;
    logic [7:0]  angle;
    logic        angle_valid;
    logic [16:0] pulse_width;
    logic        err_short;
    logic        err_long;
    logic        signal_lost;

    servo_pwm_decoder #(
        .MIN_CYC    (MIN_CYC),
        .MAX_CYC    (MAX_CYC),
        .CYC_PER_DEG(CYC_PER_DEG),
        .MAX_ANGLE  (MAX_ANGLE),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .angle      (angle),
        .angle_valid(angle_valid),
        .pulse_width(pulse_width),
        .err_short  (err_short),
        .err_long   (err_long),
        .signal_lost(signal_lost)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // per-pulse observations
    int nv, ns, nl, lh, voff, lost_v, lost_pre, prev_lost;

    // reference model state
    int m_angle = 0;
    int m_pw    = 0;

    typedef struct {
        int hi;
        int lo;
        int ang;
        int pw;
        int v;
        int s;
        int l;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_angle(input int w);
        int a;
        a = (w - MIN_CYC) / CYC_PER_DEG;
        return (a > MAX_ANGLE) ? MAX_ANGLE : a;
    endfunction

    task automatic tally(input int off, input bit hi_phase);
        if (angle_valid) begin
            nv++;
            voff     = off;
            lost_v   = int'(signal_lost);
            lost_pre = prev_lost;
        end
        if (err_short) ns++;
        if (err_long) begin
            nl++;
            if (hi_phase) lh++;
        end
        prev_lost = int'(signal_lost);
    endtask

    // Drive one pulse: pin high for hi cycles, then low for lo cycles.
    // Called at a negedge; outputs sampled every negedge.
    task automatic run_pulse(input int hi, input int lo);
        nv = 0; ns = 0; nl = 0; lh = 0; voff = -1; lost_v = -1; lost_pre = -1;
        prev_lost = int'(signal_lost);
        pwm_in = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            tally(-1, 1'b1);
        end
        pwm_in = 1'b0;
        for (int i = 1; i <= lo; i++) begin
            @(negedge clk);
            tally(i, 1'b0);
        end
    endtask

    task automatic apply(input string tag, input int hi, input int lo,
                         input int e_ang, input int e_pw,
                         input int e_v, input int e_s, input int e_l);
        run_pulse(hi, lo);
        check($sformatf("%s.valid_cnt", tag), nv, e_v);
        check($sformatf("%s.short_cnt", tag), ns, e_s);
        check($sformatf("%s.long_cnt", tag), nl, e_l);
        check($sformatf("%s.angle", tag), int'(angle), e_ang);
        check($sformatf("%s.pulse_width", tag), int'(pulse_width), e_pw);
        check($sformatf("%s.signal_lost", tag), int'(signal_lost), 0);
        if (e_v == 1) check($sformatf("%s.valid_latency", tag), voff, 3);
        if (e_l == 1 && hi > MAX_CYC + 4) check($sformatf("%s.long_while_high", tag), lh, 1);
    endtask

    initial begin
        vecs[0]  = '{40,  400, 0,   40,  1, 0, 0};
        vecs[1]  = '{310, 400, 90,  310, 1, 0, 0};
        vecs[2]  = '{337, 400, 99,  337, 1, 0, 0};
        vecs[3]  = '{600, 400, 180, 600, 1, 0, 0};
        vecs[4]  = '{310, 400, 90,  310, 1, 0, 0};
        vecs[5]  = '{30,  400, 90,  310, 0, 1, 0};
        vecs[6]  = '{39,  400, 90,  310, 0, 1, 0};
        vecs[7]  = '{630, 400, 90,  310, 0, 0, 1};
        vecs[8]  = '{310, 400, 90,  310, 1, 0, 0};
        vecs[9]  = '{601, 400, 90,  310, 0, 0, 1};
        vecs[10] = '{41,  400, 0,   41,  1, 0, 0};
        vecs[11] = '{43,  400, 1,   43,  1, 0, 0};
        vecs[12] = '{582, 400, 180, 582, 1, 0, 0};
        vecs[13] = '{579, 400, 179, 579, 1, 0, 0};

        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        check("reset.angle", int'(angle), 0);
        check("reset.pulse_width", int'(pulse_width), 0);
        check("reset.flags", int'({angle_valid, err_short, err_long, signal_lost}), 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // table-driven vectors
        for (int i = 0; i < 14; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo,
                  vecs[i].ang, vecs[i].pw, vecs[i].v, vecs[i].s, vecs[i].l);
            m_angle = vecs[i].ang;
            m_pw    = vecs[i].pw;
        end

        // randomized pulses against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            int hi, lo, ev, es, el;
            hi = int'($urandom_range(650, 20));
            lo = int'($urandom_range(400, 8));
            ev = 0; es = 0; el = 0;
            if (hi > MAX_CYC) el = 1;
            else if (hi < MIN_CYC) es = 1;
            else begin
                ev = 1;
                m_angle = model_angle(hi);
                m_pw    = hi;
            end
            apply($sformatf("rnd%0d_w%0d", i, hi), hi, lo, m_angle, m_pw, ev, es, el);
        end

        // make the decoded state nonzero before the reset sequences
        apply("pre_reset", 310, 400, 90, 310, 1, 0, 0);

        // line high at reset release: that pulse must not be measured
        rst_n  = 1'b0;
        pwm_in = 1'b1;
        #1;
        check("rst_hi.angle_cleared", int'(angle), 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        run_pulse(200, 100);
        check("rst_hi.no_events", nv + ns + nl, 0);
        check("rst_hi.angle", int'(angle), 0);
        apply("after_rst_hi", 310, 400, 90, 310, 1, 0, 0);

        // reset asserted in the middle of a pulse
        pwm_in = 1'b1;
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst.angle", int'(angle), 0);
        check("mid_rst.pulse_width", int'(pulse_width), 0);
        check("mid_rst.flags", int'({angle_valid, err_short, err_long, signal_lost}), 0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_pulse(157, 400);
        check("mid_rst.not_decoded", nv + ns + nl, 0);
        check("mid_rst.angle_after", int'(angle), 0);
        apply("after_mid_rst", 337, 400, 99, 337, 1, 0, 0);

        // stuck low -> signal_lost, cleared with the next angle_valid
        pwm_in = 1'b0;
        repeat (TIMEOUT_CYC + 20) @(negedge clk);
        check("lost_low.signal_lost", int'(signal_lost), 1);
        run_pulse(40, 400);
        check("lost_low.valid_cnt", nv, 1);
        check("lost_low.lost_before_valid", lost_pre, 1);
        check("lost_low.lost_at_valid", lost_v, 0);
        check("lost_low.angle", int'(angle), 0);
        check("lost_low.pulse_width", int'(pulse_width), 40);

        // stuck high -> one err_long and signal_lost
        run_pulse(TIMEOUT_CYC + 50, 10);
        check("stuck_hi.long_cnt", nl, 1);
        check("stuck_hi.long_while_high", lh, 1);
        check("stuck_hi.valid_cnt", nv, 0);
        check("stuck_hi.signal_lost", int'(signal_lost), 1);
        check("stuck_hi.angle", int'(angle), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
